// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Optional pipeline-flush abort port is enabled by defining DIV_ABORT_EN.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             sign_a_in, sign_b_in;
  logic [WIDTH:0]   rem_sh, trial;

  always_comb begin
    state_d     = state_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    a_raw_d     = a_raw_q;
    b_mag_d     = b_mag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    sign_a_in = is_signed & dividend[WIDTH-1];
    sign_b_in = is_signed & divisor[WIDTH-1];
    // Partial remainder can reach 2*|b|-1, so the trial needs one extra bit
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_mag_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_a_d = sign_a_in;
          sign_b_d = sign_b_in;
          a_raw_d  = dividend;
          b_mag_d  = sign_b_in ? -divisor : divisor;
          quo_d    = sign_a_in ? -dividend : dividend;
          rem_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // A zero divisor reports all-ones and the untouched dividend
        if (b_mag_q == '0) begin
          quotient_d  = '1;
          remainder_d = a_raw_q;
        end else begin
          quotient_d  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
          remainder_d = sign_a_q ? -rem_q : rem_q;
        end
        dbz_d   = (b_mag_q == '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef DIV_ABORT_EN
    // Flush drops the operation and leaves architectural results untouched
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      a_raw_q     <= '0;
      b_mag_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      a_raw_q     <= a_raw_d;
      b_mag_q     <= b_mag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed plus random checks of iter_divider against an arithmetic reference model.
module tb_iter_divider;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
`ifdef DIV_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

  iter_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
`ifdef DIV_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, remainder follows dividend, fixed zero-divisor result
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = W'($signed(a) / $signed(b));
        r = W'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s);
    logic [W-1:0] eq, er;
    model(a, b, s, eq, er);
    chk({tag, ".quo"}, quotient, eq);
    chk({tag, ".rem"}, remainder, er);
    chk({tag, ".dbz"}, W'(div_by_zero), W'(b == '0));
    chk({tag, ".busy_at_done"}, W'(busy), '0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    int lat, bc;
    launch(a, b, s);
    wait_done(lat, bc);
    chk({tag, ".latency"}, W'(lat), W'(33));
    chk({tag, ".busy_cycles"}, W'(bc), W'(33));
    check_result(tag, a, b, s);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, W'(done), '0);
  endtask

  initial begin
    int lat, bc;
    logic seen;
    logic [W-1:0] ra, rb, sq, sr;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", W'(busy), '0);
    chk("reset.done", W'(done), '0);
    chk("reset.quo", quotient, '0);
    chk("reset.rem", remainder, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("u100_7", 32'd100, 32'd7, 1'b0);
    run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op("u5_0", 32'd5, 32'd0, 1'b0);
    run_op("s-5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
    run_op("smin_-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("umin_1", 32'h8000_0000, 32'd1, 1'b0);
    run_op("s-8_4", 32'hFFFF_FFF8, 32'd4, 1'b1);

    // Second start while busy is ignored
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    chk("ignore.latency", W'(lat), W'(23));
    check_result("ignore", 32'd100, 32'd7, 1'b0);

    // Start in the done cycle is accepted
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.busy", W'(busy), W'(1));
    wait_done(lat, bc);
    chk("b2b.latency", W'(lat), W'(33));
    check_result("b2b", 32'd1000, 32'd10, 1'b0);

    // Reset mid-operation clears outputs and suppresses done
    launch(32'd77, 32'd5, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid.busy", W'(busy), '0);
    chk("rstmid.done", W'(done), '0);
    chk("rstmid.quo", quotient, '0);
    chk("rstmid.rem", remainder, '0);
    chk("rstmid.dbz", W'(div_by_zero), '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("rstmid.no_done", W'(seen), '0);

`ifdef DIV_ABORT_EN
    run_op("pre_abort", 32'd50, 32'd6, 1'b0);
    launch(32'd99, 32'd4, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.busy", W'(busy), '0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort.no_done", W'(seen), '0);
    chk("abort.quo_kept", quotient, 32'd8);
    chk("abort.rem_kept", remainder, 32'd2);
    @(negedge clk);
    abort = 1'b1; start = 1'b1; dividend = 32'd20; divisor = 32'd3; is_signed = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_idle.busy", W'(busy), W'(1));
    wait_done(lat, bc);
    chk("abort_idle.latency", W'(lat), W'(33));
    check_result("abort_idle", 32'd20, 32'd3, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = {{(W-4){rb[3]}}, rb[3:0]};
        default: ;
      endcase
      sq = W'($urandom_range(0, 1));
      launch(ra, rb, sq[0]);
      wait_done(lat, bc);
      chk("rand.latency", W'(lat), W'(33));
      model(ra, rb, sq[0], sq, sr);
      chk("rand.quo", quotient, sq);
      chk("rand.rem", remainder, sr);
      chk("rand.dbz", W'(div_by_zero), W'(rb == '0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
